cve2_wb_stage: RTL and testbench

- Registered writeback stage for the cve2 core. Replaces the combinational passthrough.
- Holds one retiring instruction for a single cycle, then writes either the integer or the FP register file.
- Loads stall in WB until the LSU response arrives; load data goes to the RF selected by the captured destination flag.
- Produces forwarding/hazard information for ID and the retire pulses for the performance counters.

---
 rtl/cve2_pkg.sv | 10 +
 rtl/cve2_wb_stage.sv | 137 +++++++++++++
 tb/tb_cve2_wb_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cve2_pkg.sv
// Shared types for the cve2 core slice: writeback stage state encoding.
package cve2_pkg;

   typedef enum logic [1:0] {
      WB_EMPTY,
      WB_FULL,
      WB_WAIT_LSU
   } wb_state_e;

endpackage

// File: rtl/cve2_wb_stage.sv
// Registered writeback stage: holds one retiring instruction, steers it to the
// integer or FP register file, and stalls loads until the LSU responds.
module cve2_wb_stage
   import cve2_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned RegAddrW  = 5,
   parameter bit          FpEn      = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,

   // Handshake: an instruction transfers from ID on a rising clk_i edge where
   // en_wb_i & ready_wb_o; en_wb_i without ready_wb_o moves nothing.
   input  logic                 en_wb_i,
   output logic                 ready_wb_o,
   input  logic                 instr_is_compressed_id_i,
   input  logic                 instr_perf_count_id_i,
   input  logic                 instr_is_load_id_i,
   input  logic                 is_fp_dest_id_i,
   input  logic [RegAddrW-1:0]  rf_waddr_id_i,
   input  logic [DataWidth-1:0] rf_wdata_id_i,
   input  logic                 rf_we_id_i,

   input  logic                 lsu_resp_valid_i,
   input  logic                 lsu_resp_err_i,
   input  logic [DataWidth-1:0] rf_wdata_lsu_i,
   input  logic                 rf_we_lsu_i,

   output logic [RegAddrW-1:0]  rf_waddr_wb_o,
   output logic [DataWidth-1:0] rf_wdata_wb_o,
   output logic                 rf_we_wb_o,
   output logic [RegAddrW-1:0]  rf_fp_waddr_wb_o,
   output logic [DataWidth-1:0] rf_fp_wdata_wb_o,
   output logic                 rf_fp_we_wb_o,

   output logic                 rf_write_wb_o,
   output logic [DataWidth-1:0] rf_wdata_fwd_wb_o,
   output logic                 outstanding_load_wb_o,
   output logic                 perf_instr_ret_wb_o,
   output logic                 perf_instr_ret_compressed_wb_o
);

   wb_state_e              state_q, state_d;
   logic [RegAddrW-1:0]    waddr_q;
   logic [DataWidth-1:0]   wdata_q;
   logic                   we_q, fp_q, load_q, compressed_q, perf_q;
   logic                   ready, capture, commit_we;
   logic [DataWidth-1:0]   wdata_sel;
   logic                   orphan_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= WB_EMPTY;
         waddr_q      <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         fp_q         <= 1'b0;
         load_q       <= 1'b0;
         compressed_q <= 1'b0;
         perf_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            waddr_q      <= rf_waddr_id_i;
            wdata_q      <= rf_wdata_id_i;
            we_q         <= rf_we_id_i;
            fp_q         <= FpEn & is_fp_dest_id_i;
            load_q       <= instr_is_load_id_i;
            compressed_q <= instr_is_compressed_id_i;
            perf_q       <= instr_perf_count_id_i;
         end
      end
   end

   // Remembers a load dropped by reset so its late LSU response is expected.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         orphan_q <= orphan_q | (state_q == WB_WAIT_LSU);
      end else if (lsu_resp_valid_i) begin
         orphan_q <= 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      ready     = 1'b1;
      commit_we = 1'b0;
      wdata_sel = wdata_q;
      case (state_q)
         WB_EMPTY: ;
         WB_FULL: begin
            commit_we = we_q;
            state_d   = WB_EMPTY;
         end
         WB_WAIT_LSU: begin
            ready = lsu_resp_valid_i;
            if (lsu_resp_valid_i) begin
               commit_we = rf_we_lsu_i & ~lsu_resp_err_i;
               wdata_sel = rf_wdata_lsu_i;
               state_d   = WB_EMPTY;
            end
         end
         default: state_d = WB_EMPTY;
      endcase
      capture = en_wb_i & ready;
      if (capture) begin
         state_d = instr_is_load_id_i ? WB_WAIT_LSU : WB_FULL;
      end
   end

   assign ready_wb_o            = ready;
   assign rf_waddr_wb_o         = waddr_q;
   assign rf_wdata_wb_o         = wdata_sel;
   // x0 is hardwired zero; FP register 0 is an ordinary register.
   assign rf_we_wb_o            = commit_we & ~fp_q & (waddr_q != '0);
   assign rf_fp_waddr_wb_o      = FpEn ? waddr_q : '0;
   assign rf_fp_wdata_wb_o      = FpEn ? wdata_sel : '0;
   assign rf_fp_we_wb_o         = FpEn & commit_we & fp_q;
   assign rf_write_wb_o         = (state_q != WB_EMPTY) & we_q;
   assign rf_wdata_fwd_wb_o     = wdata_q;
   assign outstanding_load_wb_o = (state_q == WB_WAIT_LSU);
   assign perf_instr_ret_wb_o   = perf_q & ((state_q == WB_FULL) |
                                  ((state_q == WB_WAIT_LSU) & lsu_resp_valid_i & ~lsu_resp_err_i));
   assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & compressed_q;

   a_one_port: assert property (@(posedge clk_i) disable iff (rst_i)
      !(rf_we_wb_o && rf_fp_we_wb_o));
   a_no_stall_capture: assert property (@(posedge clk_i) disable iff (rst_i)
      !(en_wb_i && ready_wb_o && state_q == WB_WAIT_LSU && !lsu_resp_valid_i));
   a_stray_resp: assert property (@(posedge clk_i) disable iff (rst_i)
      lsu_resp_valid_i |-> (state_q == WB_WAIT_LSU || orphan_q));

   logic unused_load;
   assign unused_load = load_q;

endmodule

// File: tb/tb_cve2_wb_stage.sv
// Directed-vector bench for cve2_wb_stage: one table row per clock cycle.
module tb_cve2_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, ready, comp, perf, load, fp, we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        rv, rerr, rwe;
   logic [31:0] rdata;
   logic [4:0]  o_waddr, o_fp_waddr;
   logic [31:0] o_wdata, o_fp_wdata, o_fwd;
   logic        o_we, o_fp_we, o_rfw, o_outst, o_ret, o_retc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cve2_wb_stage #(.DataWidth(32), .RegAddrW(5), .FpEn(1'b1)) dut (
      .clk_i(clk), .rst_i(rst),
      .en_wb_i(en), .ready_wb_o(ready),
      .instr_is_compressed_id_i(comp), .instr_perf_count_id_i(perf),
      .instr_is_load_id_i(load), .is_fp_dest_id_i(fp),
      .rf_waddr_id_i(waddr), .rf_wdata_id_i(wdata), .rf_we_id_i(we),
      .lsu_resp_valid_i(rv), .lsu_resp_err_i(rerr),
      .rf_wdata_lsu_i(rdata), .rf_we_lsu_i(rwe),
      .rf_waddr_wb_o(o_waddr), .rf_wdata_wb_o(o_wdata), .rf_we_wb_o(o_we),
      .rf_fp_waddr_wb_o(o_fp_waddr), .rf_fp_wdata_wb_o(o_fp_wdata), .rf_fp_we_wb_o(o_fp_we),
      .rf_write_wb_o(o_rfw), .rf_wdata_fwd_wb_o(o_fwd),
      .outstanding_load_wb_o(o_outst),
      .perf_instr_ret_wb_o(o_ret), .perf_instr_ret_compressed_wb_o(o_retc)
   );

   typedef struct packed {
      logic        en, load, fp, comp, perf, we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        rv, rerr, rwe;
      logic [31:0] rdata;
      logic        x_ready, x_we, x_fpwe;
      logic [4:0]  x_addr;
      logic [31:0] x_data;
      logic        x_ret, x_retc, x_outst, x_rfw;
   } vec_t;

   typedef logic [80:0] obs_t;

   vec_t vecs[$];

   function automatic vec_t v(
      input logic en_, load_, fp_, comp_, perf_, we_,
      input logic [4:0] wa_, input logic [31:0] wd_,
      input logic rv_, rerr_, rwe_, input logic [31:0] rd_,
      input logic e_rdy, e_we, e_fpwe, input logic [4:0] e_a, input logic [31:0] e_d,
      input logic e_ret, e_retc, e_out, e_rfw);
      vec_t r;
      r = '{en_, load_, fp_, comp_, perf_, we_, wa_, wd_, rv_, rerr_, rwe_, rd_,
            e_rdy, e_we, e_fpwe, e_a, e_d, e_ret, e_retc, e_out, e_rfw};
      return r;
   endfunction

   task automatic drive(input vec_t r);
      en = r.en; load = r.load; fp = r.fp; comp = r.comp; perf = r.perf; we = r.we;
      waddr = r.waddr; wdata = r.wdata;
      rv = r.rv; rerr = r.rerr; rwe = r.rwe; rdata = r.rdata;
   endtask

   task automatic idle();
      drive('0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_vec(input int idx, input vec_t r);
      obs_t act, exp;
      act = {ready, o_we, o_fp_we, o_waddr, o_wdata, o_fp_waddr, o_fp_wdata,
             o_ret, o_retc, o_outst, o_rfw};
      exp = {r.x_ready, r.x_we, r.x_fpwe, r.x_addr, r.x_data, r.x_addr, r.x_data,
             r.x_ret, r.x_retc, r.x_outst, r.x_rfw};
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL row%0d: got %h expected %h", idx, act, exp);
      end
   endtask

   initial begin
      // en ld fp c pf we addr  wdata        rv er rwe rdata       | rdy we fwe addr  data        ret rc out rfw
      vecs.push_back(v(1,0,0,0,1,1, 5'd5, 32'h1234,   0,0,0, 32'h0,      1,0,0, 5'd0, 32'h0,      0,0,0,0));
      vecs.push_back(v(1,0,1,0,1,1, 5'd3, 32'hA,      0,0,0, 32'h0,      1,1,0, 5'd5, 32'h1234,   1,0,0,1));
      vecs.push_back(v(1,0,0,1,1,1, 5'd7, 32'hB,      0,0,0, 32'h0,      1,0,1, 5'd3, 32'hA,      1,0,0,1));
      vecs.push_back(v(1,1,0,0,1,1, 5'd9, 32'h0,      0,0,0, 32'h0,      1,1,0, 5'd7, 32'hB,      1,1,0,1));
      vecs.push_back(v(1,0,0,0,1,1, 5'd10,32'h55,     0,0,0, 32'h0,      0,0,0, 5'd9, 32'h0,      0,0,1,1));
      vecs.push_back(v(1,0,0,0,1,1, 5'd10,32'h55,     0,0,0, 32'h0,      0,0,0, 5'd9, 32'h0,      0,0,1,1));
      vecs.push_back(v(1,0,0,0,1,1, 5'd10,32'h55,     0,0,0, 32'h0,      0,0,0, 5'd9, 32'h0,      0,0,1,1));
      vecs.push_back(v(1,0,0,0,1,1, 5'd10,32'h55,     1,0,1, 32'hDEAD,   1,1,0, 5'd9, 32'hDEAD,   1,0,1,1));
      vecs.push_back(v(1,1,0,0,1,1, 5'd12,32'h0,      0,0,0, 32'h0,      1,1,0, 5'd10,32'h55,     1,0,0,1));
      vecs.push_back(v(0,0,0,0,0,0, 5'd0, 32'h0,      1,1,1, 32'hBEEF,   1,0,0, 5'd12,32'hBEEF,   0,0,1,1));
      vecs.push_back(v(0,0,0,0,0,0, 5'd0, 32'h0,      0,0,0, 32'h0,      1,0,0, 5'd12,32'h0,      0,0,0,0));
      vecs.push_back(v(1,0,0,0,1,1, 5'd0, 32'hFF,     0,0,0, 32'h0,      1,0,0, 5'd12,32'h0,      0,0,0,0));
      vecs.push_back(v(1,0,1,0,1,1, 5'd0, 32'hFE,     0,0,0, 32'h0,      1,0,0, 5'd0, 32'hFF,     1,0,0,1));
      vecs.push_back(v(0,0,0,0,0,0, 5'd0, 32'h0,      0,0,0, 32'h0,      1,0,1, 5'd0, 32'hFE,     1,0,0,1));
      vecs.push_back(v(1,0,0,1,0,0, 5'd4, 32'h77,     0,0,0, 32'h0,      1,0,0, 5'd0, 32'hFE,     0,0,0,0));
      vecs.push_back(v(0,0,0,0,0,0, 5'd0, 32'h0,      0,0,0, 32'h0,      1,0,0, 5'd4, 32'h77,     0,0,0,0));
      vecs.push_back(v(1,1,1,1,1,1, 5'd2, 32'h0,      0,0,0, 32'h0,      1,0,0, 5'd4, 32'h77,     0,0,0,0));
      vecs.push_back(v(0,0,0,0,0,0, 5'd0, 32'h0,      1,0,1, 32'hCAFE,   1,0,1, 5'd2, 32'hCAFE,   1,1,1,1));
      vecs.push_back(v(0,0,0,0,0,0, 5'd0, 32'h0,      0,0,0, 32'h0,      1,0,0, 5'd2, 32'h0,      0,0,0,0));

      rst = 1'b1;
      idle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_vec(-1, v(0,0,0,0,0,0, 5'd0, 32'h0, 0,0,0, 32'h0, 1,0,0, 5'd0, 32'h0, 0,0,0,0));
      check_bit("reset_fwd_zero", (o_fwd == 32'h0), 1'b1);
      next_cycle();

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(negedge clk);
         check_vec(i, vecs[i]);
         next_cycle();
      end

      // Forwarding value of a held non-load result.
      drive(v(1,0,0,0,1,1, 5'd1, 32'h99, 0,0,0, 32'h0, 0,0,0, 5'd0, 32'h0, 0,0,0,0));
      next_cycle();
      idle();
      @(negedge clk);
      check_bit("fwd_full", (o_fwd == 32'h99), 1'b1);
      next_cycle();

      // Reset while a load is outstanding; its late response must be ignored.
      drive(v(1,1,0,0,1,1, 5'd9, 32'h0, 0,0,0, 32'h0, 0,0,0, 5'd0, 32'h0, 0,0,0,0));
      next_cycle();
      idle();
      @(negedge clk);
      check_bit("rst_wait_outst", o_outst, 1'b1);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_bit("post_rst_ready", ready, 1'b1);
      check_bit("post_rst_outst", o_outst, 1'b0);
      next_cycle();
      next_cycle();
      rv = 1'b1; rwe = 1'b1; rdata = 32'hDEAD;
      @(negedge clk);
      check_bit("late_resp_we", o_we, 1'b0);
      check_bit("late_resp_fpwe", o_fp_we, 1'b0);
      check_bit("late_resp_ret", o_ret, 1'b0);
      check_bit("late_resp_ready", ready, 1'b1);
      next_cycle();
      idle();
      @(negedge clk);
      check_bit("late_resp_rfw", o_rfw, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
